// File: rtl/conv_window_feeder.sv
// conv_window_feeder
//   Sequencer in front of the 3x3 kernel window generator. On an accepted
//   start it latches the layer config, waits CFG_SETTLE cycles for the
//   generator's registered config to settle, then streams pixel vectors in
//   NHWC order. With cfg_pad set, zero vectors are injected so the generator
//   sees a (W+2)x(H+2) image.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   start               one-cycle frame start, honoured only in IDLE
//   cfg_width/height    image size W x H in pixels
//   cfg_channels        input channels C, nonzero multiple of 8
//   cfg_pad             1 = 1-pixel zero border
//   in_pixel/in_valid   upstream vector stream
//   in_ready            upstream ready (BODY only, deasserted by stall)
//   stall               downstream hold; blocks production in that cycle
//   win_pixel/win_valid registered vector stream to the generator
//   gen_channels        latched C
//   gen_width           W+2 when padded, else W
//   busy                frame in progress
//   done                one-cycle pulse after the final vector
//   cfg_err             one-cycle pulse on a rejected start
module conv_window_feeder #(
  parameter int unsigned CFG_SETTLE = 4,
  parameter int unsigned DATA_W     = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       cfg_width,
  input  logic [15:0]       cfg_height,
  input  logic [15:0]       cfg_channels,
  input  logic              cfg_pad,
  input  logic [DATA_W-1:0] in_pixel,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              stall,
  output logic [DATA_W-1:0] win_pixel,
  output logic              win_valid,
  output logic [15:0]       gen_channels,
  output logic [15:0]       gen_width,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_TOP, S_LEFT, S_BODY, S_RIGHT, S_BOTTOM, S_FINISH
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] settle_cnt, settle_nxt;
  logic [31:0] vec_cnt, vec_nxt;
  logic [31:0] col_cnt, col_nxt;
  logic [31:0] row_cnt, row_nxt;

  // Latched per-frame config
  logic [31:0] lat_vpp, lat_w, lat_wp, lat_h;
  logic        lat_pad;

  logic        cfg_bad, accept, reject;
  logic        pad_state, produce;
  logic        last_vec, last_col, last_row;
  logic [31:0] pix_cnt;

  always_comb begin
    cfg_bad   = (cfg_channels == '0) || (cfg_channels[2:0] != '0) ||
                (cfg_width == '0) || (cfg_height == '0);
    accept    = (state == S_IDLE) && start && !cfg_bad;
    reject    = (state == S_IDLE) && start && cfg_bad;
    pad_state = (state == S_TOP) || (state == S_LEFT) ||
                (state == S_RIGHT) || (state == S_BOTTOM);
    in_ready  = (state == S_BODY) && !stall;
    // A stall and an upstream bubble in one cycle still cost only that cycle.
    produce   = (pad_state && !stall) || (in_valid && in_ready);

    case (state)
      S_TOP, S_BOTTOM: pix_cnt = lat_wp;
      S_BODY:          pix_cnt = lat_w;
      default:         pix_cnt = 32'd1;
    endcase

    last_vec = (vec_cnt == lat_vpp - 32'd1);
    last_col = (col_cnt == pix_cnt - 32'd1);
    last_row = (row_cnt == lat_h - 32'd1);

    state_nxt  = state;
    settle_nxt = settle_cnt;
    vec_nxt    = vec_cnt;
    col_nxt    = col_cnt;
    row_nxt    = row_cnt;

    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt  = S_SETTLE;
          settle_nxt = '0;
          vec_nxt    = '0;
          col_nxt    = '0;
          row_nxt    = '0;
        end
      end
      S_SETTLE: begin
        if (settle_cnt == CFG_SETTLE - 1) state_nxt = lat_pad ? S_TOP : S_BODY;
        else                              settle_nxt = settle_cnt + 32'd1;
      end
      S_FINISH: state_nxt = S_IDLE;
      default: begin
        // Streaming states: the transition fires on the producing cycle of
        // the last vector so consecutive segments have no dead cycle.
        if (produce) begin
          vec_nxt = last_vec ? '0 : vec_cnt + 32'd1;
          if (last_vec) begin
            col_nxt = last_col ? '0 : col_cnt + 32'd1;
            if (last_col) begin
              case (state)
                S_TOP:  state_nxt = S_LEFT;
                S_LEFT: state_nxt = S_BODY;
                S_BODY: begin
                  if (lat_pad)       state_nxt = S_RIGHT;
                  else if (last_row) state_nxt = S_FINISH;
                  else               row_nxt   = row_cnt + 32'd1;
                end
                S_RIGHT: begin
                  if (last_row) state_nxt = S_BOTTOM;
                  else begin
                    state_nxt = S_LEFT;
                    row_nxt   = row_cnt + 32'd1;
                  end
                end
                S_BOTTOM: state_nxt = S_FINISH;
                default:  state_nxt = state;
              endcase
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      settle_cnt   <= '0;
      vec_cnt      <= '0;
      col_cnt      <= '0;
      row_cnt      <= '0;
      lat_vpp      <= '0;
      lat_w        <= '0;
      lat_wp       <= '0;
      lat_h        <= '0;
      lat_pad      <= 1'b0;
      win_pixel    <= '0;
      win_valid    <= 1'b0;
      gen_channels <= '0;
      gen_width    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      vec_cnt    <= vec_nxt;
      col_cnt    <= col_nxt;
      row_cnt    <= row_nxt;
      win_valid  <= produce;
      if (produce) win_pixel <= pad_state ? '0 : in_pixel;
      done       <= (state == S_FINISH);
      cfg_err    <= reject;
      if (accept) begin
        lat_vpp      <= {19'd0, cfg_channels[15:3]};
        lat_w        <= {16'd0, cfg_width};
        lat_h        <= {16'd0, cfg_height};
        lat_wp       <= {16'd0, cfg_width} + (cfg_pad ? 32'd2 : 32'd0);
        lat_pad      <= cfg_pad;
        gen_channels <= cfg_channels;
        gen_width    <= cfg_width + (cfg_pad ? 16'd2 : 16'd0);
        busy         <= 1'b1;
      end else if (state == S_FINISH) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed testbench for conv_window_feeder: padded/unpadded frames,
// multi-vector pixels, upstream bubbles, downstream stall, mid-frame reset
// and rejected / ignored starts.
module tb_conv_window_feeder;

  logic        clk = 1'b0;
  logic        rst_n, start, cfg_pad, in_valid, in_ready, stall;
  logic [15:0] cfg_width, cfg_height, cfg_channels;
  logic [63:0] in_pixel, win_pixel;
  logic        win_valid, busy, done, cfg_err;
  logic [15:0] gen_channels, gen_width;

  conv_window_feeder #(.CFG_SETTLE(4), .DATA_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_channels(cfg_channels), .cfg_pad(cfg_pad),
    .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
    .stall(stall), .win_pixel(win_pixel), .win_valid(win_valid),
    .gen_channels(gen_channels), .gen_width(gen_width),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int src_idx  = 0;
  int ir_cnt   = 0;
  int stall_viol = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [63:0] q[$];
  int          vt[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Output collector, sampled mid-cycle
  always @(negedge clk) begin
    if (win_valid) begin
      q.push_back(win_pixel);
      vt.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic logic [63:0] pix(input int i);
    return 64'hC0DE_0000_0000_0100 + 64'(i);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Upstream source advances on each accepted handshake.
  task automatic tick();
    bit hs;
    #1;
    hs = in_valid && in_ready;
    if (in_ready) ir_cnt++;
    if (in_ready && stall) stall_viol++;
    @(posedge clk);
    #1;
    if (hs) begin
      src_idx++;
      in_pixel = pix(src_idx);
    end
  endtask

  // k counts cycles after the edge that accepted start.
  task automatic run_frame(input string tag, input int w, input int h, input int c,
                           input bit pad, input bit toggle,
                           input int s1, input int l1, input int s2, input int l2,
                           input int poke, input int exp_ir, input int exp_gap,
                           input int exp_maxgap);
    int vpp, wp, hp, total, base, k, dc0, ei, st_cyc, gaps, maxgap, bad, g, first;
    logic [63:0] exp_q[$];
    vpp = c / 8; wp = w + 2 * int'(pad); hp = h + 2 * int'(pad);
    total = wp * hp * vpp; base = src_idx; ei = 0;
    for (int y = 0; y < hp; y++)
      for (int x = 0; x < wp; x++)
        for (int v = 0; v < vpp; v++)
          if (pad && (y == 0 || y == hp - 1 || x == 0 || x == wp - 1))
            exp_q.push_back(64'd0);
          else begin
            exp_q.push_back(pix(base + ei));
            ei++;
          end
    q.delete(); vt.delete();
    dc0 = done_cnt; ir_cnt = 0; stall_viol = 0;
    cfg_width = 16'(w); cfg_height = 16'(h); cfg_channels = 16'(c); cfg_pad = pad;
    in_valid = 1'b0; stall = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; st_cyc = cyc;
    check({tag, " busy_on"}, 64'(busy), 64'd1);
    check({tag, " gen_width"}, 64'(gen_width), 64'(wp));
    check({tag, " gen_channels"}, 64'(gen_channels), 64'(c));
    k = 0;
    while (done_cnt == dc0 && k < 600) begin
      stall    = (k >= s1 && k < s1 + l1) || (k >= s2 && k < s2 + l2);
      in_valid = toggle ? (k % 2 == 0) : 1'b1;
      start    = (k == poke);
      cfg_width = (k == poke) ? 16'(w + 5) : 16'(w);
      tick();
      k++;
    end
    stall = 1'b0; in_valid = 1'b0; start = 1'b0; cfg_width = 16'(w);
    check({tag, " done_pulses"}, 64'(done_cnt - dc0), 64'd1);
    check({tag, " valid_count"}, 64'(q.size()), 64'(total));
    first = (vt.size() > 0) ? vt[0] : -1000;
    check({tag, " first_latency"}, 64'(first - st_cyc), 64'd5);
    bad = 0;
    for (int i = 0; i < total; i++)
      if (i >= q.size() || q[i] !== exp_q[i]) bad++;
    check({tag, " data_mismatches"}, 64'(bad), 64'd0);
    if (vt.size() > 0) check({tag, " done_timing"}, 64'(done_cyc - vt[vt.size() - 1]), 64'd1);
    else check({tag, " done_timing"}, 64'(vt.size()), 64'(total));
    gaps = 0; maxgap = 0;
    for (int i = 1; i < vt.size(); i++) begin
      g = vt[i] - vt[i - 1] - 1;
      gaps += g;
      if (g > maxgap) maxgap = g;
    end
    check({tag, " gap_total"}, 64'(gaps), 64'(exp_gap));
    check({tag, " gap_max"}, 64'(maxgap), 64'(exp_maxgap));
    check({tag, " in_ready_cycles"}, 64'(ir_cnt), 64'(exp_ir));
    check({tag, " ready_while_stalled"}, 64'(stall_viol), 64'd0);
    check({tag, " busy_off"}, 64'(busy), 64'd0);
  endtask

  int b, dc0, qs;

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_pad = 1'b0; in_valid = 1'b0; stall = 1'b0;
    cfg_width = '0; cfg_height = '0; cfg_channels = '0; in_pixel = pix(0);
    repeat (3) tick();
    check("rst win_valid", 64'(win_valid), 64'd0);
    check("rst win_pixel", win_pixel, 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst cfg_err", 64'(cfg_err), 64'd0);
    check("rst gen_channels", 64'(gen_channels), 64'd0);
    check("rst gen_width", 64'(gen_width), 64'd0);
    rst_n = 1'b1;
    tick();

    // W=4 H=3 C=8 padded, continuous
    run_frame("c1", 4, 3, 8, 1'b1, 1'b0, -1, 0, -1, 0, -1, 12, 0, 0);

    // W=2 H=2 C=16 padded: two vectors per pixel
    b = src_idx;
    run_frame("c2", 2, 2, 16, 1'b1, 1'b0, -1, 0, -1, 0, -1, 8, 0, 0);
    check("c2 pos10", q[10], pix(b));
    check("c2 pos11", q[11], pix(b + 1));

    // W=3 H=2 C=8 unpadded, in_valid 1010..., start poked while busy
    run_frame("c3", 3, 2, 8, 1'b0, 1'b1, -1, 0, -1, 0, 8, 11, 5, 1);
    check("c3 gen_width_kept", 64'(gen_width), 64'd3);
    qs = q.size(); dc0 = done_cnt;
    repeat (10) tick();
    check("c3 no_second_frame", 64'(q.size() - qs), 64'd0);
    check("c3 no_extra_done", 64'(done_cnt - dc0), 64'd0);

    // Config 1 with 3-cycle stall in TOP and 2-cycle stall in BODY row 0
    run_frame("c4", 4, 3, 8, 1'b1, 1'b0, 6, 3, 16, 2, -1, 12, 5, 3);

    // Reset during BODY row 1, then a clean frame
    cfg_width = 16'd4; cfg_height = 16'd3; cfg_channels = 16'd8; cfg_pad = 1'b1;
    in_valid = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; dc0 = done_cnt;
    for (int k = 0; k < 18; k++) tick();
    check("rst_mid pre busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    tick();
    check("rst_mid win_valid", 64'(win_valid), 64'd0);
    check("rst_mid win_pixel", win_pixel, 64'd0);
    check("rst_mid in_ready", 64'(in_ready), 64'd0);
    check("rst_mid busy", 64'(busy), 64'd0);
    check("rst_mid gen_width", 64'(gen_width), 64'd0);
    check("rst_mid gen_channels", 64'(gen_channels), 64'd0);
    rst_n = 1'b1;
    q.delete();
    repeat (4) tick();
    check("rst_mid idle in_ready", 64'(in_ready), 64'd0);
    check("rst_mid no_valid", 64'(q.size()), 64'd0);
    check("rst_mid no_done", 64'(done_cnt - dc0), 64'd0);
    in_valid = 1'b0;
    run_frame("c5", 4, 3, 8, 1'b1, 1'b0, -1, 0, -1, 0, -1, 12, 0, 0);

    // Rejected starts
    q.delete();
    cfg_channels = 16'd12; start = 1'b1;
    tick();
    start = 1'b0;
    check("err12 cfg_err", 64'(cfg_err), 64'd1);
    check("err12 busy", 64'(busy), 64'd0);
    tick();
    check("err12 pulse_end", 64'(cfg_err), 64'd0);
    cfg_channels = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("err0 cfg_err", 64'(cfg_err), 64'd1);
    check("err0 busy", 64'(busy), 64'd0);
    repeat (8) tick();
    check("err no_valid", 64'(q.size()), 64'd0);
    check("err busy_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
